// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry FIFO of decoded instructions.
// Optional macro DECODE_MULDIV_EN adds M-extension decode with muldiv_out/mdFunc_out.
package decode_queue_pkg;
  typedef enum logic [3:0] {
    NOP = 4'd0, OP = 4'd1, OPIMM = 4'd2, LUI = 4'd3, AUIPC = 4'd4,
    JAL = 4'd5, JALR = 4'd6, BRANCH = 4'd7, LOAD = 4'd8, STORE = 4'd9
  } itype_e;

  typedef enum logic [3:0] {
    Add = 4'd0, Sub = 4'd1, And = 4'd2, Or = 4'd3, Xor = 4'd4, Slt = 4'd5,
    Sltu = 4'd6, Sll = 4'd7, Srl = 4'd8, Sra = 4'd9, NoAlu = 4'd15
  } alu_e;

  // AT marks unconditional jumps, Dbr marks "not a branch"
  typedef enum logic [2:0] {
    Eq = 3'd0, Neq = 3'd1, Lt = 3'd2, Ltu = 3'd3, Ge = 3'd4, Geu = 3'd5,
    AT = 3'd6, Dbr = 3'd7
  } br_e;

  function automatic alu_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return Add;
      3'd1:    return Sll;
      3'd2:    return Slt;
      3'd3:    return Sltu;
      3'd4:    return Xor;
      3'd5:    return Srl;
      3'd6:    return Or;
      default: return And;
    endcase
  endfunction
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       inst_valid_in,
  input  logic [31:0]                inst_in,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       inst_ready_out,
  output logic                       dec_valid_out,
  input  logic                       dec_ready_in,
  output logic [3:0]                 iType_out,
  output logic [3:0]                 aluFunc_out,
  output logic [2:0]                 brFunc_out,
  output logic [31:0]                imm_out,
  output logic [4:0]                 rs1_out,
  output logic [4:0]                 rs2_out,
  output logic [4:0]                 rd_out,
  output logic [PC_W-1:0]            pc_out,
  output logic                       illegal_out,
`ifdef DECODE_MULDIV_EN
  output logic                       muldiv_out,
  output logic [2:0]                 mdFunc_out,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [3:0]      itype;
    logic [3:0]      alu;
    logic [2:0]      br;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            ill;
`ifdef DECODE_MULDIV_EN
    logic            md;
    logic [2:0]      mdf;
`endif
    logic [PC_W-1:0] pc;
  } entry_t;

  logic [6:0]  opcode_s, funct7_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        bad_s;
  entry_t      dec_s;

  assign opcode_s = inst_in[6:0];
  assign funct3_s = inst_in[14:12];
  assign funct7_s = inst_in[31:25];
  assign imm_i_s  = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s_s  = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b_s  = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_u_s  = {inst_in[31:12], 12'h000};
  assign imm_j_s  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};

  // Combinational RV32I decode of the instruction offered by fetch.
  always_comb begin
    dec_s       = '0;
    dec_s.itype = NOP;
    dec_s.alu   = NoAlu;
    dec_s.br    = Dbr;
    dec_s.pc    = pc_in;
    bad_s       = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec_s.itype = OP;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rs2   = inst_in[24:20];
        dec_s.rd    = inst_in[11:7];
        if (funct7_s == 7'h00) begin
          dec_s.alu = alu_from_f3(funct3_s);
        end else if (funct7_s == 7'h20 && funct3_s == 3'd0) begin
          dec_s.alu = Sub;
        end else if (funct7_s == 7'h20 && funct3_s == 3'd5) begin
          dec_s.alu = Sra;
`ifdef DECODE_MULDIV_EN
        end else if (funct7_s == 7'h01) begin
          dec_s.md  = 1'b1;
          dec_s.mdf = funct3_s;
`endif
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_s.itype = OPIMM;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rd    = inst_in[11:7];
        dec_s.imm   = imm_i_s;
        // shift amounts only use imm[4:0]; imm[11:5] selects logical vs arithmetic
        if (funct3_s == 3'd1) begin
          if (funct7_s == 7'h00) dec_s.alu = Sll;
          else                   bad_s = 1'b1;
        end else if (funct3_s == 3'd5) begin
          if (funct7_s == 7'h00)      dec_s.alu = Srl;
          else if (funct7_s == 7'h20) dec_s.alu = Sra;
          else                        bad_s = 1'b1;
        end else begin
          dec_s.alu = alu_from_f3(funct3_s);
        end
      end
      OPC_LOAD: begin
        dec_s.itype = LOAD;
        dec_s.alu   = Add;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rd    = inst_in[11:7];
        dec_s.imm   = imm_i_s;
        if (funct3_s == 3'd3 || funct3_s > 3'd5) bad_s = 1'b1;
        else                                     bad_s = 1'b0;
      end
      OPC_STORE: begin
        dec_s.itype = STORE;
        dec_s.alu   = Add;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rs2   = inst_in[24:20];
        dec_s.imm   = imm_s_s;
        if (funct3_s > 3'd2) bad_s = 1'b1;
        else                 bad_s = 1'b0;
      end
      OPC_BRANCH: begin
        dec_s.itype = BRANCH;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rs2   = inst_in[24:20];
        dec_s.imm   = imm_b_s;
        case (funct3_s)
          3'd0:    dec_s.br = Eq;
          3'd1:    dec_s.br = Neq;
          3'd4:    dec_s.br = Lt;
          3'd5:    dec_s.br = Ge;
          3'd6:    dec_s.br = Ltu;
          3'd7:    dec_s.br = Geu;
          default: bad_s = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_s.itype = (opcode_s == OPC_LUI) ? LUI : AUIPC;
        dec_s.alu   = Add;
        dec_s.rd    = inst_in[11:7];
        dec_s.imm   = imm_u_s;
      end
      OPC_JAL: begin
        dec_s.itype = JAL;
        dec_s.alu   = Add;
        dec_s.br    = AT;
        dec_s.rd    = inst_in[11:7];
        dec_s.imm   = imm_j_s;
      end
      OPC_JALR: begin
        dec_s.itype = JALR;
        dec_s.alu   = Add;
        dec_s.br    = AT;
        dec_s.rs1   = inst_in[19:15];
        dec_s.rd    = inst_in[11:7];
        dec_s.imm   = imm_i_s;
        if (funct3_s != 3'd0) bad_s = 1'b1;
        else                  bad_s = 1'b0;
      end
      OPC_SYSTEM: bad_s = 1'b0;
      default:    bad_s = 1'b1;
    endcase
    if (bad_s) begin
      dec_s       = '0;
      dec_s.itype = NOP;
      dec_s.alu   = NoAlu;
      dec_s.br    = Dbr;
      dec_s.ill   = 1'b1;
      dec_s.pc    = pc_in;
    end else begin
      dec_s.ill   = 1'b0;
    end
  end

  entry_t             mem_q [DEPTH];
  entry_t             head_s;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_s, pop_s;

  assign inst_ready_out = (count_q < CNT_W'(DEPTH));
  assign dec_valid_out  = (count_q != '0);
  assign push_s         = inst_valid_in && inst_ready_out && !flush_in;
  assign pop_s          = dec_valid_out && dec_ready_in && !flush_in;

  // Pointer and occupancy next-state; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk_in) begin
    if (push_s) mem_q[wr_ptr_q] <= dec_s;
  end

  assign head_s      = mem_q[rd_ptr_q];
  assign iType_out   = dec_valid_out ? head_s.itype : 4'd0;
  assign aluFunc_out = dec_valid_out ? head_s.alu   : 4'd0;
  assign brFunc_out  = dec_valid_out ? head_s.br    : 3'd0;
  assign imm_out     = dec_valid_out ? head_s.imm   : 32'd0;
  assign rs1_out     = dec_valid_out ? head_s.rs1   : 5'd0;
  assign rs2_out     = dec_valid_out ? head_s.rs2   : 5'd0;
  assign rd_out      = dec_valid_out ? head_s.rd    : 5'd0;
  assign pc_out      = dec_valid_out ? head_s.pc    : '0;
  assign illegal_out = dec_valid_out ? head_s.ill   : 1'b0;
`ifdef DECODE_MULDIV_EN
  assign muldiv_out  = dec_valid_out ? head_s.md    : 1'b0;
  assign mdFunc_out  = dec_valid_out ? head_s.mdf   : 3'd0;
`endif
  assign count_out   = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model.
module tb_decode_queue;
  import decode_queue_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, iv, dr;
  logic [31:0] inst, pc;
  logic        inst_ready, dec_valid, illegal;
  logic [3:0]  itype, alu;
  logic [2:0]  br;
  logic [31:0] imm, pc_o;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  count;
`ifdef DECODE_MULDIV_EN
  logic        muldiv;
  logic [2:0]  mdfunc;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [3:0]  it;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic        ill;
    logic        md;
    logic [2:0]  mdf;
  } exp_t;
  exp_t mq[$];

  decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .inst_valid_in(iv),
    .inst_in(inst), .pc_in(pc), .inst_ready_out(inst_ready),
    .dec_valid_out(dec_valid), .dec_ready_in(dr), .iType_out(itype),
    .aluFunc_out(alu), .brFunc_out(br), .imm_out(imm), .rs1_out(rs1),
    .rs2_out(rs2), .rd_out(rd), .pc_out(pc_o), .illegal_out(illegal),
`ifdef DECODE_MULDIV_EN
    .muldiv_out(muldiv), .mdFunc_out(mdfunc),
`endif
    .count_out(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    int f3, f7;
    bit ok;
    logic [3:0] alu_by_f3 [8];
    logic [2:0] br_by_f3 [8];
    logic [31:0] ii, si, bi, ui, ji;
    alu_by_f3 = '{Add, Sll, Slt, Sltu, Xor, Srl, Or, And};
    br_by_f3  = '{Eq, Neq, Dbr, Dbr, Lt, Ge, Ltu, Geu};
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    ii = {20'd0, w[31:20]};
    if (w[31]) ii = ii - 32'h1000;
    si = {20'd0, w[31:25], w[11:7]};
    if (w[31]) si = si - 32'h1000;
    bi = {19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0};
    if (w[31]) bi = bi - 32'h2000;
    ji = {11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0};
    if (w[31]) ji = ji - 32'h200000;
    ui = w & 32'hFFFFF000;
    e = '{default: 0};
    e.pc = a; e.it = NOP; e.alu = NoAlu; e.br = Dbr;
    ok = 1'b1;
    case (w[6:0])
      7'b0110011: begin
        e.it = OP; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        if (f7 == 0) e.alu = alu_by_f3[f3];
        else if (f7 == 32 && f3 == 0) e.alu = Sub;
        else if (f7 == 32 && f3 == 5) e.alu = Sra;
`ifdef DECODE_MULDIV_EN
        else if (f7 == 1) begin e.md = 1'b1; e.mdf = w[14:12]; end
`endif
        else ok = 1'b0;
      end
      7'b0010011: begin
        e.it = OPIMM; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = ii;
        e.alu = alu_by_f3[f3];
        if (f3 == 5 && f7 == 32) e.alu = Sra;
        else if ((f3 == 1 || f3 == 5) && f7 != 0) ok = 1'b0;
      end
      7'b0000011: begin
        e.it = LOAD; e.alu = Add; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = ii;
        if (f3 == 3 || f3 > 5) ok = 1'b0;
      end
      7'b0100011: begin
        e.it = STORE; e.alu = Add; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = si;
        if (f3 > 2) ok = 1'b0;
      end
      7'b1100011: begin
        e.it = BRANCH; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = bi;
        e.br = br_by_f3[f3];
        if (e.br == Dbr) ok = 1'b0;
      end
      7'b0110111: begin e.it = LUI;   e.alu = Add; e.rd = w[11:7]; e.imm = ui; end
      7'b0010111: begin e.it = AUIPC; e.alu = Add; e.rd = w[11:7]; e.imm = ui; end
      7'b1101111: begin e.it = JAL; e.alu = Add; e.br = AT; e.rd = w[11:7]; e.imm = ji; end
      7'b1100111: begin
        e.it = JALR; e.alu = Add; e.br = AT; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = ii;
        if (f3 != 0) ok = 1'b0;
      end
      7'b1110011: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '{default: 0};
      e.pc = a; e.it = NOP; e.alu = NoAlu; e.br = Dbr; e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] ops [11];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b0001111};
    w = $urandom;
    if ($urandom_range(0, 11) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    if (w[6:0] == 7'b0110011 || (w[6:0] == 7'b0010011 && w[13:12] == 2'b01)) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (w[6:0] == 7'b1100111 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  // reference model: queue of decoded entries, updated with the same edge rules
  always @(posedge clk) begin
    if (rst || flush) mq.delete();
    else if (iv && mq.size() < DEPTH && mq.size() > 0 && dr) begin
      void'(mq.pop_front());
      mq.push_back(ref_decode(inst, pc));
    end
    else if (iv && mq.size() < DEPTH) mq.push_back(ref_decode(inst, pc));
    else if (mq.size() > 0 && dr) void'(mq.pop_front());
  end

  task automatic compare_outputs();
    exp_t e;
    e = '{default: 0};
    if (mq.size() > 0) e = mq[0];
    chk("count", 64'(count), 64'(mq.size()));
    chk("inst_ready", 64'(inst_ready), 64'(mq.size() < DEPTH));
    chk("dec_valid", 64'(dec_valid), 64'(mq.size() > 0));
    chk("head", {itype, alu, 1'b0, br, rs1, rs2, rd, illegal, imm},
                {e.it, e.alu, 1'b0, e.br, e.rs1, e.rs2, e.rd, e.ill, e.imm});
    chk("pc_out", 64'(pc_o), 64'(e.pc));
`ifdef DECODE_MULDIV_EN
    chk("muldiv", 64'({muldiv, mdfunc}), 64'({e.md, e.mdf}));
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_outputs();
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; dr = 1'b0; inst = 32'd0; pc = 32'd0;
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(inst_ready), 64'd1);
    chk("rst_valid", 64'(dec_valid), 64'd0);

    iv = 1'b1; inst = 32'hFFF00093; pc = 32'h100;
    cyc();
    iv = 1'b0;
    chk("addi_valid", 64'(dec_valid), 64'd1);
    chk("addi_it", 64'(itype), 64'(OPIMM));
    chk("addi_alu", 64'(alu), 64'(Add));
    chk("addi_rd_rs1", 64'({rd, rs1}), 64'({5'd1, 5'd0}));
    chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
    dr = 1'b1;
    cyc();
    dr = 1'b0;

    iv = 1'b1; inst = 32'hFE000EE3; pc = 32'h200;
    cyc();
    inst = 32'h4041D113; pc = 32'h204;
    cyc();
    iv = 1'b0;
    chk("beq_it_br", 64'({itype, br}), 64'({BRANCH, Eq}));
    chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
    dr = 1'b1;
    cyc();
    chk("srai_it_alu", 64'({itype, alu}), 64'({OPIMM, Sra}));
    chk("srai_rd_rs1", 64'({rd, rs1}), 64'({5'd2, 5'd3}));
    cyc();
    dr = 1'b0;

    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; inst = {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}; pc = 32'h300 + 32'(4 * i);
      cyc();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(inst_ready), 64'd0);
    iv = 1'b0; dr = 1'b1;
    chk("full_head_rd", 64'(rd), 64'd1);
    repeat (4) cyc();
    chk("drain_count", 64'(count), 64'd0);
    dr = 1'b0;

    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; inst = 32'h00500113; pc = 32'h400 + 32'(4 * i);
      cyc();
    end
    flush = 1'b1; dr = 1'b1;
    cyc();
    flush = 1'b0; iv = 1'b0; dr = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    chk("flush_fields", {itype, alu, rd, rs1, imm}, 64'd0);

    iv = 1'b1; inst = 32'h023100B3; pc = 32'h500;
    cyc();
    iv = 1'b0;
`ifdef DECODE_MULDIV_EN
    chk("mul_md", 64'({muldiv, mdfunc, illegal}), 64'({1'b1, 3'd0, 1'b0}));
    chk("mul_it", 64'(itype), 64'(OP));
`else
    chk("mul_ill", 64'(illegal), 64'd1);
    chk("mul_it", 64'(itype), 64'(NOP));
`endif
    dr = 1'b1;
    cyc();
    dr = 1'b0;

    iv = 1'b1; inst = 32'h0000007F; pc = 32'h600;
    cyc();
    chk("unk_ill", 64'(illegal), 64'd1);
    inst = 32'hFFF00093; pc = 32'h604;
    cyc();
    iv = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_ready", 64'(inst_ready), 64'd1);

    for (int n = 0; n < 800; n++) begin
      iv    = ($urandom_range(0, 3) != 0);
      inst  = rand_inst();
      pc    = $urandom;
      dr    = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; iv = 1'b0; dr = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, setting the decoded-entry queue depth (power of two, 2..16).
REQ-002 The module SHALL have parameter PC_W, default 32, setting the width of the program-counter tag carried with each instruction.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port flush_in, input, 1 bit: discard all queued entries and any same-cycle push.
REQ-006 The module SHALL have port inst_valid_in, input, 1 bit: fetch offers inst_in/pc_in this cycle.
REQ-007 The module SHALL have port inst_in, input, 32 bits: raw RV32I instruction.
REQ-008 The module SHALL have port pc_in, input, PC_W bits: address of inst_in.
REQ-009 The module SHALL have port inst_ready_out, output, 1 bit: queue can accept an instruction.
REQ-010 The module SHALL have port dec_valid_out, output, 1 bit: head entry is valid.
REQ-011 The module SHALL have port dec_ready_in, input, 1 bit: consumer takes the head entry.
REQ-012 The module SHALL have output ports iType_out[3:0], aluFunc_out[3:0] and brFunc_out[2:0], using the types.svh encodings.
REQ-013 The module SHALL have output ports imm_out[31:0] (signed), rs1_out[4:0], rs2_out[4:0], rd_out[4:0] and pc_out[PC_W-1:0] for the head entry.
REQ-014 The module SHALL have port illegal_out, output, 1 bit: the head entry is an unrecognised or malformed encoding.
REQ-015 The module SHALL have port count_out, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-016 The decode SHALL be combinational on inst_in; decoded fields plus pc_in SHALL be written into the queue on push (inst_valid_in && inst_ready_out && !flush_in).
REQ-017 Latency SHALL be exactly one cycle: an entry pushed in cycle N SHALL be visible at the head in cycle N+1 if the queue was empty.
REQ-018 Pop SHALL occur on dec_valid_out && dec_ready_in; simultaneous push and pop SHALL leave count_out unchanged.
REQ-019 inst_ready_out SHALL be (count_out < DEPTH); no pass-through when full, even if a pop occurs that cycle.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-021 When dec_valid_out=0, all decoded outputs, pc_out and illegal_out SHALL be 0.
REQ-022 I/S/B/J immediates SHALL be sign-extended from inst_in[31]; U immediates SHALL be {inst[31:12],12'b0}.
REQ-023 Unused rs1/rs2/rd fields SHALL be 0 (rd=0 for S/B; rs1=rs2=0 for U/J; rs2=0 for I).
REQ-024 OPIMM shifts SHALL require imm[11:5]=0x00 (slli/srli) or 0x20 (srai); any other value SHALL be illegal.
REQ-025 R-type SHALL require funct7 0x00, or 0x20 only for sub/sra; JALR SHALL require funct3=0; branches with funct3 2 or 3 SHALL be illegal.
REQ-026 Opcode 1110011 (SYSTEM) SHALL decode as iType NOP, aluFunc NoAlu, illegal_out=0.
REQ-027 Unknown opcodes or malformed fields SHALL produce iType NOP, aluFunc NoAlu, brFunc Dbr, illegal_out=1, and the entry SHALL still be queued.
REQ-028 flush_in SHALL set count_out to 0 and both pointers to 0 on the next edge, with priority over any push or pop that cycle.

Reset
REQ-029 While rst_in=1 at an edge, count_out, both pointers and dec_valid_out SHALL become 0, and inst_ready_out SHALL become 1 on the following cycle.
REQ-030 Reset mid-stream SHALL discard all queued entries; no entry SHALL reappear after reset.

Configuration
REQ-031 Macro DECODE_MULDIV_EN, when defined, SHALL add outputs muldiv_out (1 bit) and mdFunc_out[2:0], and SHALL decode R-type funct7=0x01 as a legal M-extension op: iType OP, aluFunc NoAlu, muldiv_out=1, mdFunc_out=funct3.
REQ-032 Without DECODE_MULDIV_EN, those ports SHALL be absent and funct7=0x01 SHALL be illegal.

Verification
REQ-033 Push 0xFFF00093 (addi x1,x0,-1) into the empty queue -> next cycle: dec_valid_out=1, iType OPIMM, aluFunc Add, rd=1, rs1=0, imm=0xFFFFFFFF.
REQ-034 Push 0xFE000EE3 (beq x0,x0,-4) and 0x4041D113 (srai x2,x3,4) -> popped in order as BRANCH/Eq with imm=0xFFFFFFFC, then OPIMM/Sra with rd=2, rs1=3.
REQ-035 With DEPTH=4 and dec_ready_in=0, push 5 instructions -> count_out=4, inst_ready_out=0, 5th not accepted; raise dec_ready_in -> entries pop in order and pointers wrap correctly.
REQ-036 With 3 entries queued, assert flush_in together with a push and a pop -> next cycle: count_out=0, dec_valid_out=0, all fields 0.
REQ-037 Push 0x023100B3 (mul x1,x2,x3) -> with DECODE_MULDIV_EN: muldiv_out=1, mdFunc_out=0, illegal_out=0; without it: illegal_out=1, iType NOP.
REQ-038 Push 0x0000007F (unknown opcode), then assert rst_in with 2 entries queued -> first: illegal_out=1; after reset: count_out=0 and inst_ready_out=1.
